// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared constants for the instruction fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    localparam logic [1:0] TRAP_NONE   = 2'b00;
    localparam logic [1:0] TRAP_EBREAK = 2'b01;
    localparam logic [1:0] TRAP_ECALL  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/if_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : if_queue_mem
//  Description : DEPTH x 2*XLEN entry store, sync write, async read, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_queue_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [2*XLEN-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [2*XLEN-1:0]        rdata
);

    logic [2*XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue
//  Description : Fetch-to-decode FIFO with flush, sticky ebreak/ecall trap
//                and a free-running accepted-push counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_inst,
    output logic [XLEN-1:0]        out_pc,
    input  logic                   flush,
    output logic                   trap,
    output logic [1:0]             trap_code,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            fetched
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   c_depth  = CW'(DEPTH);
    localparam logic [XLEN-1:0] c_ebreak = XLEN'(INST_EBREAK);
    localparam logic [XLEN-1:0] c_ecall  = XLEN'(INST_ECALL);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_trap;
    logic [1:0]        r_trap_code;
    logic [31:0]       r_fetched;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_rd_data;

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready  = ((r_count < c_depth) | out_ready) & ~flush & ~r_trap;
    assign out_valid = (r_count != '0) & ~flush & ~r_trap;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    if_queue_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({in_inst, in_pc}),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    assign out_inst  = w_rd_data[2*XLEN-1:XLEN];
    assign out_pc    = w_rd_data[XLEN-1:0];
    assign count     = r_count;
    assign trap      = r_trap;
    assign trap_code = r_trap_code;
    assign fetched   = r_fetched;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_trap      <= 1'b0;
            r_trap_code <= TRAP_NONE;
            r_fetched   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_fetched <= r_fetched + 32'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Trap is sticky: once set, w_pop stays low so this never re-fires.
            if (w_pop && (out_inst == c_ebreak)) begin
                r_trap      <= 1'b1;
                r_trap_code <= TRAP_EBREAK;
            end else if (w_pop && (out_inst == c_ecall)) begin
                r_trap      <= 1'b1;
                r_trap_code <= TRAP_ECALL;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_queue
//  Description : Directed self-checking bench for if_fetch_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;
    logic        trap;
    logic [1:0]  trap_code;
    logic [2:0]  count;
    logic [31:0] fetched;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_fetched;

    if_fetch_queue #(
        .XLEN  (32),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .flush     (flush),
        .trap      (trap),
        .trap_code (trap_code),
        .count     (count),
        .fetched   (fetched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (trap !== 1'b0)      begin n_err++; $display("FAIL rst_trap: got %b expected 0", trap); end
        n_cmp++; if (trap_code !== 2'b00) begin n_err++; $display("FAIL rst_trap_code: got %b expected 00", trap_code); end
        n_cmp++; if (fetched !== 32'd0)  begin n_err++; $display("FAIL rst_fetched: got %0d expected 0", fetched); end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h0000_0013;
        in_pc    = 32'h0000_1000;
        @(negedge clk);
        in_valid = 1'b0;
        exp_fetched = 32'd1;
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL first_push_count: got %0d expected 1", count); end
        n_cmp++; if (out_pc !== 32'h1000) begin n_err++; $display("FAIL first_push_pc: got %h expected 00001000", out_pc); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL first_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = 32'h0000_0013 | (32'(i) << 20);
            in_pc    = 32'(i * 4);
            #1;
            if (i == 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got out_valid=%b expected 0", out_valid); end
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, in_ready); end
            @(negedge clk);
            exp_fetched++;
        end
        in_pc = 32'h10;
        #1;
        n_cmp++; if (count !== 3'd4)     begin n_err++; $display("FAIL full_count: got %0d expected 4", count); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_pc !== 32'h0)   begin n_err++; $display("FAIL full_head_pc: got %h expected 00000000", out_pc); end
        @(negedge clk);
        n_cmp++; if (count !== 3'd4)     begin n_err++; $display("FAIL stall_count: got %0d expected 4", count); end
        n_cmp++; if (out_pc !== 32'h0)   begin n_err++; $display("FAIL stall_head_pc: got %h expected 00000000", out_pc); end
        n_cmp++; if (fetched !== exp_fetched) begin n_err++; $display("FAIL stall_fetched: got %0d expected %0d", fetched, exp_fetched); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
            n_cmp++; if (out_pc !== 32'(i * 4)) begin n_err++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, 32'(i * 4)); end
            n_cmp++; if (out_inst !== (32'h0000_0013 | (32'(i) << 20))) begin n_err++; $display("FAIL drain_inst[%0d]: got %h expected %h", i, out_inst, 32'h0000_0013 | (32'(i) << 20)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL drained_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_inst = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h20 + 32'(i * 4);
            @(negedge clk);
            exp_fetched++;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_pc = 32'h30 + 32'(k * 4);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready); end
            n_cmp++; if (out_pc !== 32'h20 + 32'(k * 4)) begin n_err++; $display("FAIL b2b_head_pc[%0d]: got %h expected %h", k, out_pc, 32'h20 + 32'(k * 4)); end
            @(negedge clk);
            exp_fetched++;
            n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d expected 4", k, count); end
            n_cmp++; if (fetched !== exp_fetched) begin n_err++; $display("FAIL b2b_fetched[%0d]: got %0d expected %0d", k, fetched, exp_fetched); end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_pc !== 32'h30 + 32'(k * 4)) begin n_err++; $display("FAIL b2b_drain_pc[%0d]: got %h expected %h", k, out_pc, 32'h30 + 32'(k * 4)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_inst = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h40 + 32'(i * 4);
            @(negedge clk);
            exp_fetched++;
        end
        in_pc     = 32'h4C;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_cmp++; if (fetched !== exp_fetched) begin n_err++; $display("FAIL flush_fetched: got %0d expected %0d", fetched, exp_fetched); end
        in_valid = 1'b1;
        in_pc    = 32'h50;
        @(negedge clk);
        in_valid = 1'b0;
        exp_fetched++;
        n_cmp++; if (out_pc !== 32'h50) begin n_err++; $display("FAIL post_flush_head: got %h expected 00000050", out_pc); end
        n_cmp++; if (count !== 3'd1)    begin n_err++; $display("FAIL post_flush_count: got %0d expected 1", count); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_ebreak();
        in_valid = 1'b1;
        in_inst  = 32'h0000_0013;
        in_pc    = 32'h60;
        @(negedge clk);
        in_inst  = 32'h0010_0073;
        in_pc    = 32'h64;
        @(negedge clk);
        in_valid = 1'b0;
        exp_fetched += 2;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL trap_early: got %b expected 0", trap); end
        n_cmp++; if (out_inst !== 32'h0010_0073) begin n_err++; $display("FAIL ebreak_head: got %h expected 00100073", out_inst); end
        @(negedge clk);
        n_cmp++; if (trap !== 1'b1)       begin n_err++; $display("FAIL ebreak_trap: got %b expected 1", trap); end
        n_cmp++; if (trap_code !== 2'b01) begin n_err++; $display("FAIL ebreak_code: got %b expected 01", trap_code); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL ebreak_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL ebreak_out_valid: got %b expected 0", out_valid); end
        in_valid = 1'b1;
        in_inst  = 32'h0000_0013;
        in_pc    = 32'h68;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (fetched !== exp_fetched) begin n_err++; $display("FAIL trap_no_push: got %0d expected %0d", fetched, exp_fetched); end
        n_cmp++; if (trap !== 1'b1 || trap_code !== 2'b01) begin n_err++; $display("FAIL trap_sticky: got %b/%b expected 1/01", trap, trap_code); end
    endtask

    task automatic test_ecall_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_fetched = 32'd0;
        in_valid = 1'b1;
        in_inst  = 32'h0000_0073;
        in_pc    = 32'h70;
        @(negedge clk);
        in_inst  = 32'h0000_0013;
        in_pc    = 32'h74;
        @(negedge clk);
        in_pc    = 32'h78;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (trap !== 1'b1)       begin n_err++; $display("FAIL ecall_trap: got %b expected 1", trap); end
        n_cmp++; if (trap_code !== 2'b10) begin n_err++; $display("FAIL ecall_code: got %b expected 10", trap_code); end
        n_cmp++; if (count !== 3'd2)      begin n_err++; $display("FAIL ecall_count: got %0d expected 2", count); end
        n_cmp++; if (fetched !== 32'd3)   begin n_err++; $display("FAIL ecall_fetched: got %0d expected 3", fetched); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0)      begin n_err++; $display("FAIL async_count: got %0d expected 0", count); end
        n_cmp++; if (trap !== 1'b0)       begin n_err++; $display("FAIL async_trap: got %b expected 0", trap); end
        n_cmp++; if (trap_code !== 2'b00) begin n_err++; $display("FAIL async_code: got %b expected 00", trap_code); end
        n_cmp++; if (fetched !== 32'd0)   begin n_err++; $display("FAIL async_fetched: got %0d expected 0", fetched); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetched_wrap();
        @(negedge clk);
        force dut.r_fetched = 32'hFFFF_FFFF;
        #1 release dut.r_fetched;
        #1;
        n_cmp++; if (fetched !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h expected ffffffff", fetched); end
        in_valid = 1'b1;
        in_inst  = 32'h0000_0013;
        in_pc    = 32'h80;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (fetched !== 32'd0) begin n_err++; $display("FAIL wrap_fetched: got %h expected 00000000", fetched); end
        n_cmp++; if (count !== 3'd1)    begin n_err++; $display("FAIL wrap_count: got %0d expected 1", count); end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_fetched = 32'd0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_inst     = 32'd0;
        in_pc       = 32'd0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_ebreak();
        test_ecall_reset();
        test_fetched_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the instruction and PC width.
REQ-002 The block SHALL take parameter DEPTH, default 4, as the queue depth; it SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream fetch data valid.
REQ-006 in_ready  out  1  queue accepts a push this cycle.
REQ-007 in_inst  in  XLEN  fetched instruction.
REQ-008 in_pc  in  XLEN  PC paired with in_inst.
REQ-009 out_valid  out  1  head entry valid toward decode.
REQ-010 out_ready  in  1  decode accepts the head entry.
REQ-011 out_inst  out  XLEN  head instruction.
REQ-012 out_pc  out  XLEN  head PC.
REQ-013 flush  in  1  branch redirect; discard all queued entries.
REQ-014 trap  out  1  sticky; an ebreak or ecall has been delivered.
REQ-015 trap_code  out  2  01 = ebreak, 10 = ecall, 00 = none.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 fetched  out  32  total accepted pushes.

Function
REQ-018 The block SHALL define push as in_valid & in_ready, and pop as out_valid & out_ready.
REQ-019 The block SHALL drive in_ready = (count<DEPTH | out_ready) & !flush & !trap, which permits push and pop in the same cycle when full.
REQ-020 The block SHALL drive out_valid = (count!=0) & !flush & !trap.
REQ-021 A pushed entry SHALL appear at the head no earlier than the cycle after the push, with no same-cycle bypass.
REQ-022 Entries SHALL leave in FIFO order, and out_inst/out_pc SHALL be held stable while out_valid is high and out_ready is low.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 On push without pop, count SHALL increment; on pop without push, it SHALL decrement; on both or neither, it SHALL hold.
REQ-025 When flush is high, the next edge SHALL set count=0 and both pointers to 0, with no push and no pop that cycle.
REQ-026 Popping an entry whose inst is 32'h00100073 SHALL set trap=1 and trap_code=01 at the next edge.
REQ-027 Popping an entry whose inst is 32'h00000073 SHALL set trap=1 and trap_code=10 at the next edge.
REQ-028 trap and trap_code SHALL hold until reset; while trap=1, no further push or pop SHALL occur.
REQ-029 fetched SHALL increment on every push, wrap from 2^32-1 to 0, and SHALL NOT be cleared by flush.
REQ-030 out_inst/out_pc SHALL reflect the storage at the read pointer even when out_valid=0; their value is don't-care then.

Reset
REQ-031 Asserting rst low SHALL immediately set count=0, both pointers to 0, trap=0, trap_code=00 and fetched=0, hence out_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.
REQ-033 Release of reset SHALL be synchronised externally, and the first push SHALL be possible on the first edge after release.

Structure
REQ-034 Shared package if_pkg SHALL hold the INST_EBREAK and INST_ECALL constants and the trap_code encoding TRAP_NONE/TRAP_EBREAK/TRAP_ECALL.
REQ-035 Entry storage SHALL be one sub-module, if_queue_mem: DEPTH x 2*XLEN, one synchronous write port, one combinational read port, no reset.
REQ-036 Pointer, count, trap and counter logic SHALL reside in if_fetch_queue.

Verification
REQ-037 Bench: push 4 entries (PC 0x0,0x4,0x8,0xC) with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> pops in order 0x0..0xC over 4 cycles.
REQ-038 Bench: full queue, in_valid=1 and out_ready=1 together -> push and pop each cycle, count stays 4, fetched increments by 1 per cycle.
REQ-039 Bench: 3 entries queued, flush pulsed 1 cycle with in_valid=1 -> out_valid=0 and in_ready=0 that cycle, count=0 next cycle, fetched unchanged by flush.
REQ-040 Bench: queue inst 0x00000013 then 0x00100073 and pop both -> trap=1, trap_code=01 one cycle after the second pop; in_ready and out_valid stay 0 thereafter.
REQ-041 Bench: drive rst low asynchronously mid-cycle with 2 entries queued -> count, trap and fetched read 0 before the next clk edge.
REQ-042 Bench: 2^32-1 pushes preloaded via force, then one more push -> fetched=0.
